// File: rtl/hsid_sq_df_acc_pkg.sv
// Shared widths and state encoding for the squared-difference accumulator.
package hsid_pkg;

  localparam int HSID_DATA_WIDTH = 16;
  localparam int HSID_MAX_VLEN   = 256;
  localparam int HSID_VLEN_WIDTH = $clog2(HSID_MAX_VLEN) + 1;
  localparam int HSID_ACC_WIDTH  = 2 * HSID_DATA_WIDTH + $clog2(HSID_MAX_VLEN);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } hsid_acc_state_t;

endpackage

// File: rtl/hsid_sq_df_acc_if.sv
// Sample stream in, vector sum out, plus start/length control and status.
interface hsid_sq_df_acc_if
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH = HSID_DATA_WIDTH,
  parameter int MAX_VLEN   = HSID_MAX_VLEN
);

  localparam int VLEN_WIDTH = $clog2(MAX_VLEN) + 1;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(MAX_VLEN);

  logic                    start;
  logic [VLEN_WIDTH-1:0]   vlen;
  logic [2*DATA_WIDTH-1:0] sq_df_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [ACC_WIDTH-1:0]    acc_out;
  logic                    acc_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    error;

  modport master (
    output start, vlen, sq_df_in, in_valid, out_ready,
    input  in_ready, acc_out, acc_valid, busy, error
  );

  modport slave (
    input  start, vlen, sq_df_in, in_valid, out_ready,
    output in_ready, acc_out, acc_valid, busy, error
  );

endinterface

// File: rtl/hsid_sq_df_acc.sv
// Accumulates vlen squared-difference beats into one sum per pixel pair.
// state | meaning
// IDLE  | waiting for start with a legal vlen
// ACC   | accepting beats, summing into acc
// DONE  | result presented on acc_out until out_ready
module hsid_sq_df_acc
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH = HSID_DATA_WIDTH,
  parameter int MAX_VLEN   = HSID_MAX_VLEN
) (
  input logic              clk,
  input logic              rst,
  hsid_sq_df_acc_if.slave  bus
);

  localparam int VLEN_WIDTH = $clog2(MAX_VLEN) + 1;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(MAX_VLEN);

  hsid_acc_state_t       state;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic [ACC_WIDTH-1:0]  acc_out_q;
  logic [VLEN_WIDTH-1:0] count;
  logic [VLEN_WIDTH-1:0] vlen_q;
  logic                  in_ready_q;
  logic                  acc_valid_q;
  logic                  busy_q;
  logic                  error_q;
  logic                  beat;
  logic                  last_beat;
  logic                  vlen_ok;
  logic                  take_start;

  // in_ready is a registered copy of (state == ACC), so beat acceptance
  // never depends combinationally on in_valid.
  always_comb begin
    acc_sum    = acc + ACC_WIDTH'(bus.sq_df_in);
    beat       = bus.in_valid && in_ready_q;
    last_beat  = beat && (count == (vlen_q - VLEN_WIDTH'(1)));
    vlen_ok    = (bus.vlen != '0) && (bus.vlen <= VLEN_WIDTH'(MAX_VLEN));
    take_start = bus.start &&
                 ((state == IDLE) || ((state == DONE) && bus.out_ready));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      acc_out_q   <= '0;
      count       <= '0;
      vlen_q      <= '0;
      in_ready_q  <= 1'b0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      error_q <= take_start && !vlen_ok;
      case (state)
        IDLE: begin
          if (take_start && vlen_ok) begin
            vlen_q     <= bus.vlen;
            acc        <= '0;
            count      <= '0;
            state      <= ACC;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACC: begin
          if (last_beat) begin
            acc         <= acc_sum;
            acc_out_q   <= acc_sum;
            state       <= DONE;
            in_ready_q  <= 1'b0;
            acc_valid_q <= 1'b1;
          end else if (beat) begin
            acc   <= acc_sum;
            count <= count + VLEN_WIDTH'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            acc_valid_q <= 1'b0;
            // Back-to-back: a legal start in the handshake cycle skips IDLE.
            if (take_start && vlen_ok) begin
              vlen_q     <= bus.vlen;
              acc        <= '0;
              count      <= '0;
              state      <= ACC;
              in_ready_q <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          acc_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_hsid_sq_df_acc.sv
// Scoreboard bench for hsid_sq_df_acc: sums queued at stimulus, popped on acc_valid.
module tb_hsid_sq_df_acc;
  import hsid_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int tests_run = 0;
  int tests_failed = 0;
  logic [39:0] exp_q[$];
  logic [31:0] beats_q[$];

  always #5 clk = ~clk;

  hsid_sq_df_acc_if bus ();

  hsid_sq_df_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [8:0] v);
    bus.start = 1'b1;
    bus.vlen  = v;
    step();
    bus.start = 1'b0;
  endtask

  // Drives beats_q back to back and pushes their sum as the expected result.
  task automatic send_beats(input bit push_exp);
    logic [39:0] sum;
    sum = '0;
    foreach (beats_q[i]) begin
      bus.in_valid = 1'b1;
      bus.sq_df_in = beats_q[i];
      sum = sum + 40'(beats_q[i]);
      step();
    end
    bus.in_valid = 1'b0;
    if (push_exp) exp_q.push_back(sum);
    beats_q.delete();
  endtask

  task automatic check_result(input string name);
    int waited;
    logic [39:0] exp;
    waited = 0;
    while (bus.acc_valid !== 1'b1 && waited < 600) begin
      step();
      waited++;
    end
    tests_run++;
    if (bus.acc_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s timeout: acc_valid=%b required 1", name, bus.acc_valid);
    end else if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: acc_out=%h with no expected result queued", name, bus.acc_out);
    end else begin
      exp = exp_q.pop_front();
      if (bus.acc_out !== exp) begin
        tests_failed++;
        $display("FAIL %s: acc_out=%h required %h", name, bus.acc_out, exp);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.in_ready, bus.acc_valid, bus.busy, bus.error} !== 4'b0 || bus.acc_out !== 40'd0) begin
      tests_failed++;
      $display("FAIL reset_state: rdy/vld/busy/err=%b%b%b%b acc_out=%h required 0",
               bus.in_ready, bus.acc_valid, bus.busy, bus.error, bus.acc_out);
    end
  endtask

  task automatic test_basic_sum();
    start_vec(9'd4);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_enter_acc: busy=%b in_ready=%b required 1 1", bus.busy, bus.in_ready);
    end
    beats_q.push_back(32'd4);
    beats_q.push_back(32'd9);
    beats_q.push_back(32'd16);
    send_beats(1'b0);
    tests_run++;
    if (bus.acc_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_early_valid: acc_valid=%b required 0", bus.acc_valid);
    end
    bus.in_valid = 1'b1;
    bus.sq_df_in = 32'd1;
    exp_q.push_back(40'd30);
    step();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.acc_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_latency: acc_valid=%b in_ready=%b required 1 0", bus.acc_valid, bus.in_ready);
    end
    check_result("basic_sum");
    tests_run++;
    if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0 || bus.acc_out !== 40'd30) begin
      tests_failed++;
      $display("FAIL basic_after_handshake: acc_valid=%b busy=%b acc_out=%h required 0 0 1e",
               bus.acc_valid, bus.busy, bus.acc_out);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals[3];
    vals[0] = 32'd25;
    vals[1] = 32'd0;
    vals[2] = 32'd100;
    start_vec(9'd3);
    exp_q.push_back(40'd125);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.sq_df_in = vals[i];
      step();
      bus.in_valid = 1'b0;
      bus.sq_df_in = 32'hDEAD_BEEF;
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          step();
          tests_run++;
          if (bus.in_ready !== 1'b1 || bus.acc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_gap: in_ready=%b acc_valid=%b required 1 0",
                     bus.in_ready, bus.acc_valid);
          end
        end
      end
    end
    check_result("backpressure_sum");
  endtask

  task automatic test_illegal_len();
    logic [8:0] bad[2];
    bad[0] = 9'd0;
    bad[1] = 9'd257;
    for (int i = 0; i < 2; i++) begin
      start_vec(bad[i]);
      tests_run++;
      if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_len_%0d: error=%b busy=%b in_ready=%b required 1 0 0",
                 bad[i], bus.error, bus.busy, bus.in_ready);
      end
      step();
      tests_run++;
      if (bus.error !== 1'b0 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_pulse_%0d: error=%b busy=%b required 0 0", bad[i], bus.error, bus.busy);
      end
    end
  endtask

  task automatic test_max_magnitude();
    start_vec(9'd256);
    for (int i = 0; i < 256; i++) beats_q.push_back(32'hFFFE_0001);
    send_beats(1'b1);
    tests_run++;
    if (exp_q.size() != 1 || exp_q[0] !== 40'hFF_FE00_0100) begin
      tests_failed++;
      $display("FAIL max_model: queued expectation wrong, size=%0d required 40'hfffe000100", exp_q.size());
    end
    check_result("max_magnitude");
  endtask

  task automatic test_back_to_back();
    logic [39:0] held;
    start_vec(9'd2);
    beats_q.push_back(32'd10);
    beats_q.push_back(32'd20);
    send_beats(1'b0);
    held = 40'd30;
    for (int c = 0; c < 5; c++) begin
      bus.start = (c == 2);
      bus.vlen  = 9'd5;
      step();
      bus.start = 1'b0;
      tests_run++;
      if (bus.acc_valid !== 1'b1 || bus.acc_out !== held || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_cycle_%0d: acc_valid=%b acc_out=%h in_ready=%b required 1 %h 0",
                 c, bus.acc_valid, bus.acc_out, bus.in_ready, held);
      end
    end
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    bus.vlen = 9'd2;
    step();
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1 || bus.acc_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_no_idle: in_ready=%b busy=%b acc_valid=%b required 1 1 0",
               bus.in_ready, bus.busy, bus.acc_valid);
    end
    beats_q.push_back(32'd3);
    beats_q.push_back(32'd4);
    send_beats(1'b1);
    check_result("b2b_second_sum");
  endtask

  task automatic test_reset_mid_vector();
    start_vec(9'd8);
    beats_q.push_back(32'd100);
    beats_q.push_back(32'd200);
    beats_q.push_back(32'd300);
    send_beats(1'b0);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.in_ready, bus.acc_valid, bus.busy, bus.error} !== 4'b0 || bus.acc_out !== 40'd0) begin
      tests_failed++;
      $display("FAIL reset_async: rdy/vld/busy/err=%b%b%b%b acc_out=%h required 0",
               bus.in_ready, bus.acc_valid, bus.busy, bus.error, bus.acc_out);
    end
    step();
    rst = 1'b0;
    step();
    start_vec(9'd2);
    beats_q.push_back(32'd5);
    beats_q.push_back(32'd6);
    send_beats(1'b1);
    check_result("after_reset_sum");
  endtask

  task automatic test_vlen_one();
    start_vec(9'd1);
    beats_q.push_back(32'h0001_2345);
    send_beats(1'b1);
    tests_run++;
    if (bus.acc_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL vlen_one_latency: acc_valid=%b required 1", bus.acc_valid);
    end
    check_result("vlen_one_sum");
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.vlen      = '0;
    bus.sq_df_in  = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_basic_sum();
    test_backpressure();
    test_illegal_len();
    test_max_magnitude();
    test_vlen_one();
    test_back_to_back();
    test_reset_mid_vector();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
